// File: rtl/fir_decimator_top.sv
// ============================================================================
// Module      : fir_decimator_top
// Description : FM audio L+R lowpass. Input FIFO -> 32-tap decimate-by-8
//               fixed-point FIR -> first-word-fall-through output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fm_coeffs_pkg;
    // Q10 symmetric lowpass for the L+R audio channel
    parameter logic signed [31:0] AUDIO_LPR_COEFFS [0:31] = '{
        -3, -5, -6, -4, 2, 11, 20, 23,
        12, -13, -41, -55, -28, 52, 174, 290,
        290, 174, 52, -28, -55, -41, -13, 12,
        23, 20, 11, 2, -4, -6, -5, -3
    };
endpackage

// ============================================================================
// Module      : fir_fifo
// Description : Synchronous FIFO with combinational (fall-through) head.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign w_pop   = rd_en && !w_empty;
    // a pop in the same cycle frees the slot, so a full FIFO can still take a push
    assign w_push  = wr_en && (!w_full || w_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr[ADDR_W-1:0]] <= wr_data;
    end

    assign full    = w_full;
    assign empty   = w_empty;
    assign rd_data = w_empty ? '0 : r_mem[r_rd_ptr[ADDR_W-1:0]];
endmodule

// ============================================================================
// Module      : fir_decimator_top
// Description : Decimating FIR stage, one output per DECIM inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_decimator_top #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_TAPS   = 32,
    parameter int DECIM      = 8,
    parameter int QUANT_BITS = 10,
    parameter int FIFO_DEPTH = 16,
    parameter logic signed [DATA_WIDTH-1:0] COEFFS [NUM_TAPS] = fm_coeffs_pkg::AUDIO_LPR_COEFFS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  in_wr_en,
    output logic                  in_full,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic                  out_rd_en,
    output logic                  out_empty
);
    localparam int CNT_W = $clog2(DECIM);
    localparam int TAP_W = $clog2(NUM_TAPS);

    localparam logic [1:0] S_SHIFT = 2'd0;
    localparam logic [1:0] S_MAC   = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0]                    r_state;
    logic [CNT_W-1:0]              r_count;
    logic [TAP_W-1:0]              r_tap;
    logic [DATA_WIDTH-1:0]         r_acc;
    logic signed [DATA_WIDTH-1:0]  r_x [NUM_TAPS];

    logic [DATA_WIDTH-1:0]         w_in_data;
    logic                          w_in_empty;
    logic                          w_in_pop;
    logic                          w_out_full;
    logic                          w_out_push;
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic [DATA_WIDTH-1:0]         w_term;

    fir_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_in_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (in_wr_en),
        .wr_data (din),
        .full    (in_full),
        .rd_en   (w_in_pop),
        .rd_data (w_in_data),
        .empty   (w_in_empty)
    );

    fir_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (w_out_push),
        .wr_data (r_acc),
        .full    (w_out_full),
        .rd_en   (out_rd_en),
        .rd_data (dout),
        .empty   (out_empty)
    );

    assign w_in_pop   = (r_state == S_SHIFT) && !w_in_empty;
    assign w_out_push = (r_state == S_WRITE) && !w_out_full;

    // full-precision product, floor-shifted, then truncated into the wrapping accumulator
    assign w_prod = r_x[r_tap] * COEFFS[r_tap];
    assign w_term = DATA_WIDTH'(w_prod >>> QUANT_BITS);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_SHIFT;
            r_count <= '0;
            r_tap   <= '0;
            r_acc   <= '0;
            for (int i = 0; i < NUM_TAPS; i++) r_x[i] <= '0;
        end else begin
            case (r_state)
                S_SHIFT: begin
                    if (w_in_pop) begin
                        for (int i = NUM_TAPS - 1; i > 0; i--) r_x[i] <= r_x[i-1];
                        r_x[0] <= w_in_data;
                        if (r_count == CNT_W'(DECIM - 1)) begin
                            r_count <= '0;
                            r_tap   <= '0;
                            r_acc   <= '0;
                            r_state <= S_MAC;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + w_term;
                    if (r_tap == TAP_W'(NUM_TAPS - 1)) begin
                        r_tap   <= '0;
                        r_state <= S_WRITE;
                    end else begin
                        r_tap <= r_tap + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (!w_out_full) begin
                        r_count <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                default: r_state <= S_SHIFT;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_fir_decimator_top.sv
// ============================================================================
// Module      : tb_fir_decimator_top
// Description : Self-checking bench for fir_decimator_top.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_decimator_top;
    logic        clock;
    logic        reset;
    logic [31:0] din;
    logic        in_wr_en;
    logic        in_full;
    logic [31:0] dout;
    logic        out_rd_en;
    logic        out_empty;

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [31:0] coeff [32] = '{
        -3, -5, -6, -4, 2, 11, 20, 23,
        12, -13, -41, -55, -28, 52, 174, 290,
        290, 174, 52, -28, -55, -41, -13, 12,
        23, 20, 11, 2, -4, -6, -5, -3
    };

    logic [31:0] hist  [$];
    logic [31:0] exp_q [$];

    typedef struct {
        bit          rst_before;
        logic [31:0] din;
        bit          has_out;
        logic [31:0] expected;
    } vec_t;
    vec_t vecs [$];

    fir_decimator_top dut (
        .clock     (clock),
        .reset     (reset),
        .din       (din),
        .in_wr_en  (in_wr_en),
        .in_full   (in_full),
        .dout      (dout),
        .out_rd_en (out_rd_en),
        .out_empty (out_empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
                     name, $signed(act), act, $signed(exp), exp);
        end
    endtask

    // y[n] = sum over taps of floor(x*c / 1024), window ending at the newest sample
    task automatic model_push(input logic [31:0] v);
        logic [31:0] y;
        int          newest;
        longint      s;
        longint      p;
        hist.push_back(v);
        if (hist.size() % 8 == 0) begin
            y      = '0;
            newest = hist.size() - 1;
            for (int i = 0; i < 32; i++) begin
                s = (newest - i >= 0) ? longint'($signed(hist[newest - i])) : 64'sd0;
                p = s * longint'(coeff[i]);
                y = y + 32'(p >>> 10);
            end
            exp_q.push_back(y);
        end
    endtask

    task automatic push(input logic [31:0] v);
        int waited;
        waited = 0;
        @(negedge clock);
        while (in_full && waited < 1000) begin
            @(negedge clock);
            waited++;
        end
        if (in_full) begin
            check("push_timeout", 32'(in_full), 32'd0);
            return;
        end
        din      = v;
        in_wr_en = 1'b1;
        @(posedge clock);
        #1 in_wr_en = 1'b0;
        model_push(v);
    endtask

    task automatic pop_check(input string name, input logic [31:0] exp);
        int waited;
        waited = 0;
        @(negedge clock);
        while (out_empty && waited < 400) begin
            @(negedge clock);
            waited++;
        end
        if (out_empty) begin
            check({name, "_timeout"}, 32'(out_empty), 32'd0);
            return;
        end
        check(name, dout, exp);
        out_rd_en = 1'b1;
        @(posedge clock);
        #1 out_rd_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        in_wr_en  = 1'b0;
        out_rd_en = 1'b0;
        #1;
        check("rst_in_full", 32'(in_full), 32'd0);
        check("rst_out_empty", 32'(out_empty), 32'd1);
        check("rst_dout", dout, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        hist.delete();
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        int stuck;
        reset     = 1'b1;
        din       = '0;
        in_wr_en  = 1'b0;
        out_rd_en = 1'b0;

        // impulse of 1024 (=1.0 in Q10) reads out taps 7,15,23,31; constant 1 exposes floor shift
        for (int i = 0; i < 32; i++)
            vecs.push_back('{rst_before: (i == 0), din: (i == 0) ? 32'd1024 : 32'd0,
                             has_out: (i % 8 == 7), expected: 32'd0});
        vecs[7].expected  = 32'd23;
        vecs[15].expected = 32'd290;
        vecs[23].expected = 32'd12;
        vecs[31].expected = 32'hFFFF_FFFD;
        for (int i = 0; i < 16; i++)
            vecs.push_back('{rst_before: (i == 0), din: 32'd1,
                             has_out: (i % 8 == 7), expected: 32'd0});
        vecs[39].expected = 32'hFFFF_FFFC;
        vecs[47].expected = 32'hFFFF_FFF8;

        for (int k = 0; k < vecs.size(); k++) begin
            if (vecs[k].rst_before) do_reset();
            push(vecs[k].din);
            if (vecs[k].has_out) pop_check($sformatf("vec%0d", k), vecs[k].expected);
        end

        // 100 random samples -> 12 outputs, 4 left buffered
        do_reset();
        for (int k = 0; k < 100; k++) push($urandom);
        while (exp_q.size() > 0) pop_check("rand_out", exp_q.pop_front());
        repeat (100) @(negedge clock);
        check("rand_no_extra", 32'(out_empty), 32'd1);

        // backpressure: output FIFO fills, FSM stalls in WRITE, input FIFO fills
        do_reset();
        accepted = 0;
        stuck    = 0;
        while (stuck < 120 && accepted < 400) begin
            @(negedge clock);
            if (!in_full) begin
                din      = $urandom;
                in_wr_en = 1'b1;
                @(posedge clock);
                #1 in_wr_en = 1'b0;
                model_push(din);
                accepted++;
                stuck = 0;
            end else begin
                stuck++;
            end
        end
        check("bp_accepted", 32'(accepted), 32'd152);
        check("bp_in_full", 32'(in_full), 32'd1);
        check("bp_out_nonempty", 32'(out_empty), 32'd0);
        while (exp_q.size() > 0) pop_check("bp_drain", exp_q.pop_front());
        repeat (100) @(negedge clock);
        check("bp_out_empty_end", 32'(out_empty), 32'd1);
        check("bp_in_full_end", 32'(in_full), 32'd0);

        // reset in the middle of MAC with a full input FIFO
        do_reset();
        for (int k = 0; k < 24; k++) push($urandom);
        @(negedge clock);
        check("mid_pre_in_full", 32'(in_full), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_out_empty", 32'(out_empty), 32'd1);
        check("mid_rst_in_full", 32'(in_full), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        hist.delete();
        exp_q.delete();
        for (int k = 0; k < 8; k++) push($urandom);
        while (exp_q.size() > 0) pop_check("mid_after_rst", exp_q.pop_front());
        repeat (60) @(negedge clock);
        check("mid_no_extra", 32'(out_empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
